// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: default widths, opcodes and the demo program image.
// Pure constants; no latency or backpressure.
package sap1_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // LDA 9; ADD A; SUB B; OUT; HLT; data words at 9..B
    localparam logic [7:0] DEMO_IMAGE [16] = '{
        {OP_LDA, 4'h9}, {OP_ADD, 4'hA}, {OP_SUB, 4'hB}, {OP_OUT, 4'h0},
        {OP_HLT, 4'h0}, 8'h00,          8'h00,          8'h00,
        8'h00,          8'h10,          8'h14,          8'h18,
        8'h00,          8'h00,          8'h00,          8'h00
    };

endpackage

// File: rtl/sap_ram.sv
// SAP-1 RAM: single synchronous write port, registered read port, no array reset.
// Read data valid one edge after rd_en_i; always accepts, no backpressure.
module sap_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_dat_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/mar_ram.sv
// SAP-1 MAR + RAM with W-bus tristate and front-panel programming (req/ack on prog_we).
// Read latency 1 edge; optional power-on image load under MEM_INIT_EN blocks all inputs while busy.
module mar_ram
    import sap1_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK_bar,
    input  logic              CLR,
    input  logic              Lm_bar,
    input  logic              CE_bar,
    input  logic [DATA_W-1:0] W_bus_in,
    output logic [DATA_W-1:0] W_bus,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_we,
    output logic              prog_ack,
    output logic              init_busy
);

    logic [ADDR_W-1:0] mar_q, mar_d;
    logic              en_q, en_d;
    logic              ack_q, ack_d;
    logic              we_q;
    logic              busy;
    logic              run_act, prog_act, prog_wr;
    logic              ram_we, ram_rd;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdat, ram_rdat;
    logic              unused_bus;

    assign unused_bus = ^W_bus_in[DATA_W-1:ADDR_W];

    assign run_act  = !prog_mode && !busy;
    assign prog_act =  prog_mode && !busy;
    assign prog_wr  = prog_act && prog_we && !we_q && !CLR;
    assign ram_rd   = run_act && !CE_bar && !CLR;

`ifdef MEM_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q;
    logic              init_busy_q;

    always_ff @(posedge CLK_bar) begin
        if (CLR) begin
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
        end else if (init_busy_q) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == {ADDR_W{1'b1}}) begin
                init_busy_q <= 1'b0;
            end
        end
    end

    assign busy      = init_busy_q;
    assign ram_we    = (init_busy_q && !CLR) || prog_wr;
    assign ram_waddr = init_busy_q ? init_cnt_q : prog_addr;
    assign ram_wdat  = init_busy_q ? DEMO_IMAGE[init_cnt_q] : prog_data;
`else
    assign busy      = 1'b0;
    assign ram_we    = prog_wr;
    assign ram_waddr = prog_addr;
    assign ram_wdat  = prog_data;
`endif

    always_comb begin
        mar_d = mar_q;
        en_d  = 1'b0;
        ack_d = prog_wr;
        if (run_act) begin
            if (!Lm_bar) begin
                mar_d = W_bus_in[ADDR_W-1:0];
            end
            en_d = !CE_bar;
        end
    end

    // we_q tracks prog_we in every mode so a level held across a mode change never re-fires
    always_ff @(posedge CLK_bar) begin
        if (CLR) begin
            mar_q <= '0;
            en_q  <= 1'b0;
            ack_q <= 1'b0;
            we_q  <= 1'b0;
        end else begin
            mar_q <= mar_d;
            en_q  <= en_d;
            ack_q <= ack_d;
            we_q  <= prog_we;
        end
    end

    sap_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i     (CLK_bar),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_dat_i  (ram_wdat),
        .rd_en_i   (ram_rd),
        .rd_addr_i (mar_q),
        .rd_dat_o  (ram_rdat)
    );

    assign W_bus     = en_q ? ram_rdat : {DATA_W{1'bz}};
    assign prog_ack  = ack_q;
    assign init_busy = busy;

endmodule

// File: tb/tb_mar_ram.sv
// Scoreboard bench for mar_ram: a reference model predicts W_bus / prog_ack per edge.
// MEM_INIT_EN adds the image-load length and restart checks.
module tb_mar_ram;
    import sap1_pkg::*;

    logic       CLK_bar = 1'b0;
    logic       CLR = 1'b0;
    logic       Lm_bar = 1'b1;
    logic       CE_bar = 1'b1;
    logic [7:0] W_bus_in = 8'h00;
    wire  [7:0] W_bus;
    logic       prog_mode = 1'b0;
    logic [3:0] prog_addr = 4'h0;
    logic [7:0] prog_data = 8'h00;
    logic       prog_we = 1'b0;
    logic       prog_ack;
    logic       init_busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_mem [16];
    logic [3:0] m_mar;
    logic       m_we;
    logic [7:0] wq[$];
    logic       aq[$];

    mar_ram dut (
        .CLK_bar   (CLK_bar),
        .CLR       (CLR),
        .Lm_bar    (Lm_bar),
        .CE_bar    (CE_bar),
        .W_bus_in  (W_bus_in),
        .W_bus     (W_bus),
        .prog_mode (prog_mode),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_we   (prog_we),
        .prog_ack  (prog_ack),
        .init_busy (init_busy)
    );

    always #5 CLK_bar = ~CLK_bar;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic lm, input logic ce, input logic [7:0] win,
                       input logic pm, input logic [3:0] pa, input logic [7:0] pd, input logic we);
        logic [7:0] exp_w;
        logic       exp_a;
        Lm_bar = lm; CE_bar = ce; W_bus_in = win;
        prog_mode = pm; prog_addr = pa; prog_data = pd; prog_we = we;
        exp_a = 1'b0;
        if (pm) begin
            exp_w = 8'hzz;
            if (we && !m_we) begin
                m_mem[pa] = pd;
                exp_a = 1'b1;
            end
        end else begin
            exp_w = ce ? 8'hzz : m_mem[m_mar];
            if (!lm) m_mar = win[3:0];
        end
        m_we = we;
        wq.push_back(exp_w);
        aq.push_back(exp_a);
        @(posedge CLK_bar); #1;
        chk(tag, W_bus, wq.pop_front());
        chk({tag, "_ack"}, {7'b0, prog_ack}, {7'b0, aq.pop_front()});
    endtask

    task automatic do_reset();
        int n;
        CLR = 1'b1; Lm_bar = 1'b1; CE_bar = 1'b1; prog_mode = 1'b0; prog_we = 1'b0;
        @(posedge CLK_bar); #1;
        CLR = 1'b0;
        m_mar = 4'h0;
        m_we = 1'b0;
        chk("rst_wbus", W_bus, 8'hzz);
        chk("rst_ack", {7'b0, prog_ack}, 8'h00);
`ifdef MEM_INIT_EN
        chk("rst_busy", {7'b0, init_busy}, 8'h01);
        n = 0;
        while (init_busy && n < 40) begin
            @(posedge CLK_bar); #1;
            n++;
        end
        chk("init_len", n[7:0], 8'd16);
        for (int i = 0; i < 16; i++) m_mem[i] = DEMO_IMAGE[i];
`else
        n = 0;
        chk("rst_busy", {7'b0, init_busy}, 8'h00);
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hxx;
        m_mar = 4'h0;
        m_we = 1'b0;
        @(negedge CLK_bar);
        do_reset();

        // program addr 0 and then addr 3 with prog_we held for 5 cycles
        cyc("p0_idle", 1, 1, 8'h00, 1, 4'h0, 8'h5C, 0);
        cyc("p0_wr",   1, 1, 8'h00, 1, 4'h0, 8'h5C, 1);
        cyc("p0_rel",  1, 1, 8'h00, 1, 4'h0, 8'h5C, 0);
        for (int i = 0; i < 5; i++) cyc("p3_hold", 1, 1, 8'h00, 1, 4'h3, 8'hA5, 1);
        cyc("p3_rel",  1, 1, 8'h00, 1, 4'h3, 8'hA5, 0);

        cyc("run_ldmar", 0, 1, 8'h03, 0, 4'h0, 8'h00, 0);
        cyc("run_rd3",   1, 0, 8'h00, 0, 4'h0, 8'h00, 0);
        cyc("run_off",   1, 1, 8'h00, 0, 4'h0, 8'h00, 0);

        // run strobes ignored while programming addr 7
        cyc("p7_idle", 0, 0, 8'h0F, 1, 4'h7, 8'h11, 0);
        cyc("p7_wr",   0, 0, 8'h0F, 1, 4'h7, 8'h11, 1);
        cyc("p7_rel",  0, 0, 8'h0F, 1, 4'h7, 8'h11, 0);
        cyc("mode_z",  1, 1, 8'h00, 0, 4'h0, 8'h00, 0);
        cyc("mar_kept", 1, 0, 8'h00, 0, 4'h0, 8'h00, 0);

        cyc("ld_rd_old", 0, 0, 8'h07, 0, 4'h0, 8'h00, 0);
        cyc("rd_new",    1, 0, 8'h00, 0, 4'h0, 8'h00, 0);

        // mode drops on the same edge prog_we rises: no write
        cyc("drop_pre", 1, 1, 8'h00, 1, 4'h7, 8'h22, 0);
        cyc("drop_we",  1, 1, 8'h00, 0, 4'h7, 8'h22, 1);
        cyc("drop_hold", 1, 1, 8'h00, 1, 4'h7, 8'h22, 1);
        cyc("drop_rel", 1, 1, 8'h00, 1, 4'h7, 8'h22, 0);
        cyc("drop_rd",  1, 0, 8'h00, 0, 4'h0, 8'h00, 0);
        cyc("run_we",   1, 1, 8'h00, 0, 4'h7, 8'h33, 1);
        cyc("run_we_rd", 1, 0, 8'h00, 0, 4'h0, 8'h00, 0);

        // reset clears MAR to 0 but leaves RAM alone
        do_reset();
        cyc("rst_rd0", 1, 0, 8'h00, 0, 4'h0, 8'h00, 0);
        cyc("rst_off", 1, 1, 8'h00, 0, 4'h0, 8'h00, 0);

`ifdef MEM_INIT_EN
        CLR = 1'b1;
        @(posedge CLK_bar); #1;
        CLR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK_bar); #1;
            chk("load_z", W_bus, 8'hzz);
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc("img_ld", 0, 1, 8'(i), 0, 4'h0, 8'h00, 0);
            cyc("img_rd", 1, 0, 8'h00, 0, 4'h0, 8'h00, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
